// File: rtl/kn_rd_pkg.sv
// Shared definitions for the kn_rd_multi LED controller: register map,
// CTRL bit layout, run modes and AXI response code.
package kn_rd_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PERIOD  = 2'd1;
    localparam logic [1:0] REG_PATTERN = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_RESTART = 3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_MANUAL = 2'd3
    } kn_mode_e;

endpackage

// File: rtl/kn_rd_engine.sv
// Pattern engine: step prescaler plus LED/direction state and the
// registered end-of-sweep pulse.
module kn_rd_engine
    import kn_rd_pkg::*;
#(
    parameter int N_LEDS      = 8,
    parameter int PRESC_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  kn_mode_e               mode_i,
    input  logic                   restart_i,
    input  logic [PRESC_WIDTH-1:0] period_i,
    input  logic [N_LEDS-1:0]      pattern_i,
    output logic [N_LEDS-1:0]      led_o,
    output logic                   dir_o,
    output logic                   sweep_o
);

    logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;
    logic [N_LEDS-1:0]      led_q, led_d;
    logic                   dir_q, dir_d;
    logic                   sweep_q, sweep_d;
    logic                   en_prev_q;
    logic                   load;
    logic                   tick;

    assign load = en_i & (~en_prev_q | restart_i);
    // PERIOD of 0 or 1 both tick every cycle; >= copes with PERIOD shrinking mid-count.
    assign tick = en_i & ((period_i <= PRESC_WIDTH'(1)) | (cnt_q >= period_i - PRESC_WIDTH'(1)));

    always_comb begin
        cnt_d   = cnt_q;
        led_d   = led_q;
        dir_d   = dir_q;
        sweep_d = 1'b0;
        if (!en_i) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = '0;
            led_d = pattern_i;
            dir_d = 1'b0;
        end else if (tick) begin
            cnt_d = '0;
            case (mode_i)
                MODE_BOUNCE: begin
                    if (!dir_q) begin
                        if (led_q[N_LEDS-1]) begin
                            dir_d   = 1'b1;
                            led_d   = led_q >> 1;
                            sweep_d = 1'b1;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            dir_d   = 1'b0;
                            led_d   = led_q << 1;
                            sweep_d = 1'b1;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
                MODE_ROTATE: begin
                    led_d   = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
                    sweep_d = led_q[N_LEDS-1];
                end
                MODE_BLINK: begin
                    if (led_q == '0) begin
                        led_d   = pattern_i;
                        sweep_d = 1'b1;
                    end else begin
                        led_d = '0;
                    end
                end
                default: ;
            endcase
        end else begin
            cnt_d = cnt_q + PRESC_WIDTH'(1);
        end
        // Manual mode mirrors PATTERN even while disabled.
        if (mode_i == MODE_MANUAL) begin
            led_d = pattern_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            led_q     <= '0;
            dir_q     <= 1'b0;
            sweep_q   <= 1'b0;
            en_prev_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            led_q     <= led_d;
            dir_q     <= dir_d;
            sweep_q   <= sweep_d;
            en_prev_q <= en_i;
        end
    end

    assign led_o   = led_q;
    assign dir_o   = dir_q;
    assign sweep_o = sweep_q;

endmodule

// File: rtl/kn_rd_multi.sv
// AXI4-Lite register file (CTRL/PERIOD/PATTERN/STATUS) in front of the
// Knight Rider pattern engine.
module kn_rd_multi
    import kn_rd_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int N_LEDS             = 8,
    parameter int PRESC_WIDTH        = 24
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [N_LEDS-1:0]             LED,
    output logic                          SWEEP_PULSE
);

    logic                          en_q, en_d;
    kn_mode_e                      mode_q, mode_d;
    logic                          restart_q, restart_d;
    logic [PRESC_WIDTH-1:0]        period_q, period_d;
    logic [N_LEDS-1:0]             pattern_q, pattern_d;
    logic                          bvalid_q, bvalid_d;
    logic                          rvalid_q, rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [C_S_AXI_DATA_WIDTH-1:0] wmask, ctrl_word, period_word, pattern_word, status_word;
    logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_new, period_new, pattern_new;
    logic [N_LEDS-1:0]             eng_led;
    logic                          eng_dir;
    logic                          wr_hs, rd_hs;
    logic [3:0]                    unused_addr_bits;

    // Handshakes: a write completes in the cycle AWVALID and WVALID are both
    // high with no response outstanding (AWREADY/WREADY are that cycle's pulse);
    // BVALID then holds until BREADY. A read completes when ARVALID is high with
    // no data outstanding; RVALID/RDATA then hold until RREADY.
    assign wr_hs = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
    assign rd_hs = S_AXI_ARVALID & ~rvalid_q;
    assign unused_addr_bits = {S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        wmask = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}},
                 {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
        ctrl_word                       = '0;
        ctrl_word[CTRL_EN]              = en_q;
        ctrl_word[CTRL_MODE_LO +: 2]    = mode_q;
        period_word                     = '0;
        period_word[PRESC_WIDTH-1:0]    = period_q;
        pattern_word                    = '0;
        pattern_word[N_LEDS-1:0]        = pattern_q;
        status_word                     = '0;
        status_word[N_LEDS-1:0]         = eng_led;
        status_word[C_S_AXI_DATA_WIDTH-1] = eng_dir;
        ctrl_new    = (ctrl_word & ~wmask) | (S_AXI_WDATA & wmask);
        period_new  = (period_word & ~wmask) | (S_AXI_WDATA & wmask);
        pattern_new = (pattern_word & ~wmask) | (S_AXI_WDATA & wmask);

        en_d      = en_q;
        mode_d    = mode_q;
        restart_d = 1'b0;
        period_d  = period_q;
        pattern_d = pattern_q;
        bvalid_d  = bvalid_q & ~S_AXI_BREADY;
        rvalid_d  = rvalid_q & ~S_AXI_RREADY;
        rdata_d   = rdata_q;

        if (wr_hs) begin
            bvalid_d = 1'b1;
            case (S_AXI_AWADDR[3:2])
                REG_CTRL: begin
                    en_d      = ctrl_new[CTRL_EN];
                    mode_d    = kn_mode_e'(ctrl_new[CTRL_MODE_LO +: 2]);
                    restart_d = ctrl_new[CTRL_RESTART];
                end
                REG_PERIOD:  period_d  = period_new[PRESC_WIDTH-1:0];
                REG_PATTERN: pattern_d = pattern_new[N_LEDS-1:0];
                default: ;
            endcase
        end

        if (rd_hs) begin
            rvalid_d = 1'b1;
            case (S_AXI_ARADDR[3:2])
                REG_CTRL:    rdata_d = ctrl_word;
                REG_PERIOD:  rdata_d = period_word;
                REG_PATTERN: rdata_d = pattern_word;
                default:     rdata_d = status_word;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            en_q      <= 1'b0;
            mode_q    <= MODE_BOUNCE;
            restart_q <= 1'b0;
            period_q  <= PRESC_WIDTH'(100);
            pattern_q <= N_LEDS'(1);
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            en_q      <= en_d;
            mode_q    <= mode_d;
            restart_q <= restart_d;
            period_q  <= period_d;
            pattern_q <= pattern_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    kn_rd_engine #(
        .N_LEDS      (N_LEDS),
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_engine (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .en_i      (en_q),
        .mode_i    (mode_q),
        .restart_i (restart_q),
        .period_i  (period_q),
        .pattern_i (pattern_q),
        .led_o     (eng_led),
        .dir_o     (eng_dir),
        .sweep_o   (SWEEP_PULSE)
    );

    assign S_AXI_AWREADY = wr_hs;
    assign S_AXI_WREADY  = wr_hs;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = rd_hs;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign S_AXI_RVALID  = rvalid_q;
    assign LED           = eng_led;

endmodule

// File: tb/tb_kn_rd_multi.sv
// Directed bench for kn_rd_multi: register map, bounce/rotate/blink stepping,
// enable/restart reloads and asynchronous reset with a response pending.
module tb_kn_rd_multi;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [3:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [7:0]  led;
    logic        sweep;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    kn_rd_multi #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .N_LEDS             (8),
        .PRESC_WIDTH        (24)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .LED           (led),
        .SWEEP_PULSE   (sweep)
    );

    // Driver: full write, returns two negedges after the handshake edge.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge ACLK);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n = 0;
        while (!(awready && wready) && n < 20) begin @(negedge ACLK); #1; n++; end
        checks++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            $display("FAIL write_handshake addr=%h: awready=%b wready=%b required 1/1", addr, awready, wready);
            errors++;
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        @(negedge ACLK);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge ACLK); n++; end
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            $display("FAIL write_resp addr=%h: bvalid=%b bresp=%b required 1/00", addr, bvalid, bresp);
            errors++;
        end
        bready = 1'b1;
        @(negedge ACLK);
        bready = 1'b0;
    endtask

    // Driver: full read.
    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int n;
        data = 'x;
        @(negedge ACLK);
        araddr = addr; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin @(negedge ACLK); #1; n++; end
        checks++;
        if (arready !== 1'b1) begin
            $display("FAIL read_handshake addr=%h: arready=%b required 1", addr, arready);
            errors++;
            arvalid = 1'b0;
            return;
        end
        @(negedge ACLK);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge ACLK); n++; end
        checks++;
        if (rvalid !== 1'b1 || rresp !== 2'b00) begin
            $display("FAIL read_resp addr=%h: rvalid=%b rresp=%b required 1/00", addr, rvalid, rresp);
            errors++;
        end
        data = rdata;
        rready = 1'b1;
        @(negedge ACLK);
        rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp_rd [4];
        exp_rd = '{32'h0, 32'd100, 32'h1, 32'h0};
        ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, sweep} !== 6'b0 || led !== 8'h00 || rdata !== 32'h0) begin
            $display("FAIL reset_outputs: rdy/vld=%b led=%h rdata=%h required 000000/00/0",
                     {awready, wready, bvalid, arready, rvalid, sweep}, led, rdata);
            errors++;
        end
        ARESETN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d);
            checks++;
            if (d !== exp_rd[i]) begin
                $display("FAIL reset_reg%0d: got %h required %h", i, d, exp_rd[i]);
                errors++;
            end
        end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        axi_write(4'h0, 32'h0000_000F, 4'hF);
        axi_write(4'h4, 32'h1234_5678, 4'hF);
        axi_write(4'h8, 32'h0000_00A5, 4'hF);
        axi_write(4'hC, 32'h0000_FFFF, 4'hF);
        axi_read(4'h0, d);
        checks++;
        if (d !== 32'h7) begin $display("FAIL ctrl_readback: got %h required %h", d, 32'h7); errors++; end
        axi_read(4'h4, d);
        checks++;
        if (d !== 32'h0034_5678) begin $display("FAIL period_readback: got %h required %h", d, 32'h0034_5678); errors++; end
        axi_read(4'h8, d);
        checks++;
        if (d !== 32'hA5) begin $display("FAIL pattern_readback: got %h required %h", d, 32'hA5); errors++; end
        axi_read(4'hC, d);
        checks++;
        if (d !== 32'hA5) begin $display("FAIL status_manual: got %h required %h", d, 32'hA5); errors++; end
        axi_write(4'h4, 32'hAABB_CCDD, 4'h2);
        axi_read(4'h4, d);
        checks++;
        if (d !== 32'h0034_CC78) begin $display("FAIL period_wstrb: got %h required %h", d, 32'h0034_CC78); errors++; end
    endtask

    task automatic test_bounce();
        logic [31:0] d;
        logic [7:0]  exp_led;
        int          pulses;
        axi_write(4'h0, 32'h0, 4'hF);
        axi_write(4'h8, 32'h01, 4'hF);
        axi_write(4'h4, 32'd2, 4'hF);
        axi_write(4'h0, 32'h1, 4'hF);
        checks++;
        if (led !== 8'h01) begin $display("FAIL bounce_load: got %h required %h", led, 8'h01); errors++; end
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge ACLK);
            if (sweep === 1'b1) pulses++;
            if (i % 2 == 0) begin
                exp_led = (i < 16) ? 8'(1 << (i / 2)) : 8'h40;
                checks++;
                if (led !== exp_led) begin
                    $display("FAIL bounce_step%0d: got %h required %h", i, led, exp_led);
                    errors++;
                end
            end
        end
        checks++;
        if (pulses != 1 || sweep !== 1'b1) begin
            $display("FAIL bounce_sweep: pulses=%0d sweep=%b required 1/1", pulses, sweep);
            errors++;
        end
        @(negedge ACLK);
        checks++;
        if (sweep !== 1'b0) begin $display("FAIL bounce_pulse_width: got %b required 0", sweep); errors++; end
        axi_read(4'hC, d);
        checks++;
        if (d !== 32'h8000_0020) begin $display("FAIL bounce_status: got %h required %h", d, 32'h8000_0020); errors++; end
    endtask

    task automatic test_rotate();
        logic [31:0] d;
        logic [7:0]  exp_seq [3];
        logic        exp_sw [3];
        exp_seq = '{8'h03, 8'h06, 8'h0C};
        exp_sw  = '{1'b1, 1'b0, 1'b0};
        axi_write(4'h0, 32'h0, 4'hF);
        axi_write(4'h8, 32'h81, 4'hF);
        axi_write(4'h4, 32'd1, 4'hF);
        axi_write(4'h0, 32'h3, 4'hF);
        checks++;
        if (led !== 8'h81) begin $display("FAIL rotate_load: got %h required %h", led, 8'h81); errors++; end
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            checks++;
            if (led !== exp_seq[i] || sweep !== exp_sw[i]) begin
                $display("FAIL rotate_step%0d: led=%h sweep=%b required %h/%b", i, led, sweep, exp_seq[i], exp_sw[i]);
                errors++;
            end
        end
        axi_write(4'h0, 32'hB, 4'hF);
        checks++;
        if (led !== 8'h81) begin $display("FAIL restart_reload: got %h required %h", led, 8'h81); errors++; end
        axi_read(4'h0, d);
        checks++;
        if (d !== 32'h3) begin $display("FAIL restart_selfclear: got %h required %h", d, 32'h3); errors++; end
    endtask

    task automatic test_blink();
        axi_write(4'h0, 32'h0, 4'hF);
        axi_write(4'h8, 32'h3C, 4'hF);
        axi_write(4'h4, 32'd3, 4'hF);
        axi_write(4'h0, 32'h5, 4'hF);
        checks++;
        if (led !== 8'h3C) begin $display("FAIL blink_load: got %h required %h", led, 8'h3C); errors++; end
        repeat (3) @(negedge ACLK);
        checks++;
        if (led !== 8'h00 || sweep !== 1'b0) begin
            $display("FAIL blink_off: led=%h sweep=%b required 00/0", led, sweep); errors++;
        end
        repeat (3) @(negedge ACLK);
        checks++;
        if (led !== 8'h3C || sweep !== 1'b1) begin
            $display("FAIL blink_on: led=%h sweep=%b required 3c/1", led, sweep); errors++;
        end
        @(negedge ACLK);
        checks++;
        if (sweep !== 1'b0) begin $display("FAIL blink_pulse_width: got %b required 0", sweep); errors++; end
        axi_write(4'h0, 32'h4, 4'hF);
        checks++;
        if (led !== 8'h00) begin $display("FAIL freeze_entry: got %h required %h", led, 8'h00); errors++; end
        repeat (6) @(negedge ACLK);
        checks++;
        if (led !== 8'h00) begin $display("FAIL freeze_hold: got %h required %h", led, 8'h00); errors++; end
        axi_write(4'h0, 32'h5, 4'hF);
        checks++;
        if (led !== 8'h3C) begin $display("FAIL enable_reload: got %h required %h", led, 8'h3C); errors++; end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] d;
        int          n;
        axi_write(4'h0, 32'h0, 4'hF);
        axi_write(4'h8, 32'h81, 4'hF);
        @(negedge ACLK);
        awaddr = 4'h0; wdata = 32'h7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 20) begin @(negedge ACLK); #1; n++; end
        checks++;
        if (awready !== 1'b1) begin $display("FAIL pend_handshake: awready=%b required 1", awready); errors++; end
        @(negedge ACLK);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge ACLK);
        checks++;
        if (bvalid !== 1'b1 || led !== 8'h81) begin
            $display("FAIL pend_state: bvalid=%b led=%h required 1/81", bvalid, led); errors++;
        end
        #2 ARESETN = 1'b0;
        #1;
        checks++;
        if (bvalid !== 1'b0 || led !== 8'h00 || rvalid !== 1'b0 || sweep !== 1'b0 || rdata !== 32'h0) begin
            $display("FAIL async_reset: bvalid=%b led=%h rvalid=%b sweep=%b rdata=%h required 0/00/0/0/0",
                     bvalid, led, rvalid, sweep, rdata);
            errors++;
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        axi_write(4'h8, 32'h5A, 4'hF);
        axi_read(4'h8, d);
        checks++;
        if (d !== 32'h5A) begin $display("FAIL post_reset_pattern: got %h required %h", d, 32'h5A); errors++; end
        axi_read(4'h4, d);
        checks++;
        if (d !== 32'd100) begin $display("FAIL post_reset_period: got %h required %h", d, 32'd100); errors++; end
        axi_read(4'h0, d);
        checks++;
        if (d !== 32'h0) begin $display("FAIL post_reset_ctrl: got %h required %h", d, 32'h0); errors++; end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_bounce();
        test_rotate();
        test_blink();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
